data_store_buffer: RTL and testbench
====================================

DATA_STORE_BUFFER -- requirements
Module: data_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..8).
REQ-002 SHALL have parameter CNT_W, default 3, width of sb_count (log2(DEPTH)+1).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cpu_addr  input  32  pipeline byte address.
REQ-006 SHALL have port cpu_write_data  input  32  store data.
REQ-007 SHALL have port cpu_memwrite  input  1  store request.
REQ-008 SHALL have port cpu_memread  input  1  load request.
REQ-009 SHALL have port cpu_sign_mask  input  4  access size/sign code, passed unchanged.
REQ-010 SHALL have port cpu_stall  output  1  pipeline must hold its current memory op.
REQ-011 SHALL have ports mem_addr/mem_write_data (output 32), mem_sign_mask (output 4), mem_memwrite/mem_memread (output 1), driving the data memory.
REQ-012 SHALL have port mem_clk_stall  input  1  data memory busy with a write.
REQ-013 SHALL have ports sb_count  output  CNT_W  valid entries; sb_empty  output  1  count==0.

Function
REQ-014 Entry SHALL hold {addr, write_data, sign_mask}; circular FIFO, head/tail pointers wrap modulo DEPTH.
REQ-015 Store with count<DEPTH SHALL enqueue at the rising edge, cpu_stall=0 (zero-cycle store).
REQ-016 Store with count==DEPTH SHALL assert cpu_stall combinationally; no enqueue, even if a pop occurs that cycle.
REQ-017 Load hazard: any valid entry with addr[31:2]==cpu_addr[31:2] SHALL assert cpu_stall until no matching entry remains.
REQ-018 Load without hazard, state IDLE, mem_clk_stall=0, count<DEPTH SHALL pass cpu_addr/sign_mask to mem_* with mem_memread=1, mem_memwrite=0, cpu_stall=0, same cycle.
REQ-019 Load while state!=IDLE or mem_clk_stall=1 SHALL assert cpu_stall.
REQ-020 FSM states IDLE, WAIT.
REQ-021 IDLE, count>0, mem_clk_stall=0, and (no load, or hazard, or count==DEPTH): drive head on mem_*, mem_memwrite=1, mem_memread=0; pop at edge; next WAIT.
REQ-022 Loads SHALL have priority over drain except when count==DEPTH (forced drain, anti-starvation).
REQ-023 WAIT: mem_memwrite=mem_memread=0; stay ≥1 cycle; return IDLE at first edge with mem_clk_stall=0 sampled.
REQ-024 Simultaneous enqueue (count<DEPTH) and pop SHALL leave count unchanged, pointers both advance.
REQ-025 Idle outputs: mem_* all zero when no load and no drain.
REQ-026 count SHALL never exceed DEPTH nor underflow; sb_empty == (sb_count==0).

Reset
REQ-027 reset SHALL asynchronously clear head, tail, count, state=IDLE; entries discarded, contents don't-care.
REQ-028 During and after reset: cpu_stall=0 (absent requests), mem_memwrite=mem_memread=0, sb_count=0, sb_empty=1.
REQ-029 Reset in WAIT SHALL abandon the issued write tracking; no replay.

Structure
REQ-030 FSM state encodings, DEPTH default and the word-address compare width (30) SHALL live in shared package sail_mem_pkg.
REQ-031 Storage+pointers SHALL be one sub-module sb_fifo (push, pop, head outputs, count); hazard compare and FSM stay in top.

Verification
REQ-032 After reset: store 0x100=0xDEADBEEF, sign_mask 4'b0100 -> cpu_stall=0, sb_count=1; next cycle (no load) mem_memwrite=1, mem_addr=0x100, mem_write_data=0xDEADBEEF.
REQ-033 Four back-to-back stores with loads holding memory, fifth store -> cpu_stall=1 at fifth, forced drain issues, fifth enqueues after a slot frees.
REQ-034 Store 0x104, immediate load 0x106 -> cpu_stall=1 until drain completes and WAIT exits; then mem_memread=1, mem_addr=0x106.
REQ-035 Load 0x200 with pending store at 0x104 -> no stall, mem_memread=1 same cycle, drain deferred.
REQ-036 Drain issued, mem_clk_stall held 1 for 3 cycles -> WAIT holds 3 cycles, loads stalled, IDLE on 4th edge.
REQ-037 Three stores queued, reset pulse mid-WAIT -> sb_count=0, sb_empty=1, no further mem_memwrite.

Source files
------------

// File: rtl/sail_mem_pkg.sv
// Shared constants for the data-memory store buffer: FSM encodings, default depth,
// word-address compare width and the buffered-store record.
package sail_mem_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned WADDR_W  = 30;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } sb_entry_t;

    // Two byte addresses hit the same 32-bit word when their upper WADDR_W bits agree.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a[31:32-WADDR_W] == b[31:32-WADDR_W];
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue: entry storage, wrapping head/tail pointers and occupancy count.
// Exposes every slot's address plus a per-slot valid mask for the load-hazard check.
module sb_fifo
    import sail_mem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [31:0]           i_push_addr,
    input  logic [31:0]           i_push_data,
    input  logic [3:0]            i_push_mask,
    output logic [31:0]           o_head_addr,
    output logic [31:0]           o_head_data,
    output logic [3:0]            o_head_mask,
    output logic [DEPTH*32-1:0]   o_entry_addr,
    output logic [DEPTH-1:0]      o_entry_valid,
    output logic [CNT_W-1:0]      o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    sb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_tail <= r_tail + 1'b1;
            if (i_pop)
                r_head <= r_head + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_tail] <= '{addr: i_push_addr, data: i_push_data, mask: i_push_mask};
    end

    // A slot is live when its distance from head (mod DEPTH) is below the count.
    always_comb begin
        o_entry_valid = '0;
        o_entry_addr  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_entry_addr[i*32 +: 32] = r_mem[i].addr;
            if (CNT_W'(PTR_W'(PTR_W'(i) - r_head)) < r_count)
                o_entry_valid[i] = 1'b1;
        end
    end

    assign o_head_addr = r_mem[r_head].addr;
    assign o_head_data = r_mem[r_head].data;
    assign o_head_mask = r_mem[r_head].mask;
    assign o_count     = r_count;

endmodule

// File: rtl/data_store_buffer.sv
// Store buffer between the pipeline and data memory: zero-cycle stores, load bypass with
// word-address hazard stall, and an IDLE/WAIT drain FSM that writes one entry per memory op.
module data_store_buffer
    import sail_mem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_write_data,
    input  logic             cpu_memwrite,
    input  logic             cpu_memread,
    input  logic [3:0]       cpu_sign_mask,
    output logic             cpu_stall,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    output logic [3:0]       mem_sign_mask,
    output logic             mem_memwrite,
    output logic             mem_memread,
    input  logic             mem_clk_stall,
    output logic [CNT_W-1:0] sb_count,
    output logic             sb_empty
);

    logic [0:0]          r_state;
    logic                w_full;
    logic                w_hazard;
    logic                w_load_go;
    logic                w_drain;
    logic                w_push;
    logic [31:0]         w_head_addr;
    logic [31:0]         w_head_data;
    logic [3:0]          w_head_mask;
    logic [DEPTH*32-1:0] w_entry_addr;
    logic [DEPTH-1:0]    w_entry_valid;
    logic [CNT_W-1:0]    w_count;

    sb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push),
        .i_pop         (w_drain),
        .i_push_addr   (cpu_addr),
        .i_push_data   (cpu_write_data),
        .i_push_mask   (cpu_sign_mask),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_head_mask   (w_head_mask),
        .o_entry_addr  (w_entry_addr),
        .o_entry_valid (w_entry_valid),
        .o_count       (w_count)
    );

    assign w_full = (w_count == CNT_W'(DEPTH));

    always_comb begin
        w_hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i] && word_match(w_entry_addr[i*32 +: 32], cpu_addr))
                w_hazard = 1'b1;
        end
    end

    // A full buffer blocks loads so the drain cannot be starved.
    assign w_load_go = cpu_memread && !w_hazard && !w_full
                     && (r_state == ST_IDLE) && !mem_clk_stall;
    assign w_drain   = (r_state == ST_IDLE) && (w_count != '0) && !mem_clk_stall
                     && (!cpu_memread || w_hazard || w_full);
    assign w_push    = cpu_memwrite && !w_full;
    assign cpu_stall = (cpu_memwrite && w_full) || (cpu_memread && !w_load_go);

    always_comb begin
        mem_addr       = '0;
        mem_write_data = '0;
        mem_sign_mask  = '0;
        mem_memwrite   = 1'b0;
        mem_memread    = 1'b0;
        if (w_load_go) begin
            mem_addr      = cpu_addr;
            mem_sign_mask = cpu_sign_mask;
            mem_memread   = 1'b1;
        end else if (w_drain) begin
            mem_addr       = w_head_addr;
            mem_write_data = w_head_data;
            mem_sign_mask  = w_head_mask;
            mem_memwrite   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_drain)        r_state <= ST_WAIT;
                ST_WAIT: if (!mem_clk_stall) r_state <= ST_IDLE;
                default:                     r_state <= ST_IDLE;
            endcase
        end
    end

    assign sb_count = w_count;
    assign sb_empty = (w_count == '0);

endmodule

// File: tb/tb_data_store_buffer.sv
// Directed bench for data_store_buffer: queue-based reference model checked every cycle,
// plus hand-computed expectations for the key store/load/drain/reset scenarios.
module tb_data_store_buffer;

    localparam int MDEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_write_data = '0;
    logic        cpu_memwrite = 1'b0;
    logic        cpu_memread = 1'b0;
    logic [3:0]  cpu_sign_mask = '0;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memwrite;
    logic        mem_memread;
    logic        mem_clk_stall = 1'b0;
    logic [2:0]  sb_count;
    logic        sb_empty;

    int n_checks = 0;
    int n_fail   = 0;

    data_store_buffer #(
        .DEPTH (4),
        .CNT_W (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_write_data (cpu_write_data),
        .cpu_memwrite   (cpu_memwrite),
        .cpu_memread    (cpu_memread),
        .cpu_sign_mask  (cpu_sign_mask),
        .cpu_stall      (cpu_stall),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_sign_mask  (mem_sign_mask),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_clk_stall  (mem_clk_stall),
        .sb_count       (sb_count),
        .sb_empty       (sb_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } ent_t;

    ent_t q[$];
    bit   busy;
    bit   model_ok = 1'b0;

    function automatic void predict(output bit stall, output bit drain, output bit load_go);
        bit full;
        bit hazard;
        full   = (q.size() == MDEPTH);
        hazard = 1'b0;
        foreach (q[k])
            if (q[k].a[31:2] == cpu_addr[31:2]) hazard = 1'b1;
        load_go = cpu_memread && !hazard && !busy && !mem_clk_stall && !full;
        drain   = !busy && (q.size() > 0) && !mem_clk_stall && !load_go;
        stall   = (cpu_memwrite && full) || (cpu_memread && !load_go);
    endfunction

    initial forever begin
        bit s, dr, lg, full;
        @(posedge clk or posedge reset);
        if (reset) begin
            q.delete();
            busy     = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            predict(s, dr, lg);
            full = (q.size() == MDEPTH);
            if (dr) begin
                void'(q.pop_front());
                busy = 1'b1;
            end else if (busy && !mem_clk_stall) begin
                busy = 1'b0;
            end
            if (cpu_memwrite && !full)
                q.push_back('{a: cpu_addr, d: cpu_write_data, m: cpu_sign_mask});
        end
    end

    initial forever begin
        bit s, dr, lg;
        @(negedge clk);
        if (model_ok) begin
            predict(s, dr, lg);
            chk("m_stall", 32'(cpu_stall), 32'(s));
            chk("m_memwrite", 32'(mem_memwrite), 32'(dr));
            chk("m_memread", 32'(mem_memread), 32'(lg));
            chk("m_count", 32'(sb_count), 32'(q.size()));
            chk("m_empty", 32'(sb_empty), 32'(q.size() == 0));
            if (lg) begin
                chk("m_addr", mem_addr, cpu_addr);
                chk("m_mask", 32'(mem_sign_mask), 32'(cpu_sign_mask));
            end else if (dr) begin
                chk("m_addr", mem_addr, q[0].a);
                chk("m_wdata", mem_write_data, q[0].d);
                chk("m_mask", 32'(mem_sign_mask), 32'(q[0].m));
            end else begin
                chk("m_addr", mem_addr, 32'h0);
                chk("m_wdata", mem_write_data, 32'h0);
                chk("m_mask", 32'(mem_sign_mask), 32'h0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input bit ms);
        @(posedge clk);
        #2;
        cpu_memwrite   = w;
        cpu_memread    = r;
        cpu_addr       = a;
        cpu_write_data = d;
        cpu_sign_mask  = m;
        mem_clk_stall  = ms;
        #1;
    endtask

    task automatic idle(input bit ms);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ms);
    endtask

    initial begin
        bit done;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(sb_count), 32'd0);
        chk("rst_empty", 32'(sb_empty), 32'd1);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_memwrite", 32'(mem_memwrite), 32'd0);
        chk("rst_memread", 32'(mem_memread), 32'd0);
        #1 reset = 1'b0;
        idle(1'b0);

        // single store then drain
        step(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'b0100, 1'b0);
        chk("st_stall", 32'(cpu_stall), 32'd0);
        chk("st_nodrain", 32'(mem_memwrite), 32'd0);
        idle(1'b0);
        chk("st_count", 32'(sb_count), 32'd1);
        chk("dr_memwrite", 32'(mem_memwrite), 32'd1);
        chk("dr_addr", mem_addr, 32'h100);
        chk("dr_wdata", mem_write_data, 32'hDEADBEEF);
        chk("dr_mask", 32'(mem_sign_mask), 32'b0100);
        chk("dr_memread", 32'(mem_memread), 32'd0);
        idle(1'b0);
        chk("wait_memwrite", 32'(mem_memwrite), 32'd0);
        chk("wait_empty", 32'(sb_empty), 32'd1);
        idle(1'b0);

        // load to a different word bypasses a pending store
        step(1'b1, 1'b0, 32'h104, 32'h11111111, 4'b0010, 1'b0);
        step(1'b0, 1'b1, 32'h200, 32'h0, 4'b0001, 1'b0);
        chk("byp_stall", 32'(cpu_stall), 32'd0);
        chk("byp_memread", 32'(mem_memread), 32'd1);
        chk("byp_addr", mem_addr, 32'h200);
        chk("byp_memwrite", 32'(mem_memwrite), 32'd0);
        idle(1'b0);
        chk("byp_late_drain", 32'(mem_memwrite), 32'd1);
        chk("byp_late_addr", mem_addr, 32'h104);
        idle(1'b0);
        idle(1'b0);

        // load to the same word as a pending store
        step(1'b1, 1'b0, 32'h104, 32'h22222222, 4'b0010, 1'b0);
        step(1'b0, 1'b1, 32'h106, 32'h0, 4'b0101, 1'b0);
        chk("haz_stall0", 32'(cpu_stall), 32'd1);
        chk("haz_drain", 32'(mem_memwrite), 32'd1);
        chk("haz_drain_addr", mem_addr, 32'h104);
        step(1'b0, 1'b1, 32'h106, 32'h0, 4'b0101, 1'b0);
        chk("haz_stall1", 32'(cpu_stall), 32'd1);
        chk("haz_wait_rd", 32'(mem_memread), 32'd0);
        step(1'b0, 1'b1, 32'h106, 32'h0, 4'b0101, 1'b0);
        chk("haz_go_stall", 32'(cpu_stall), 32'd0);
        chk("haz_go_rd", 32'(mem_memread), 32'd1);
        chk("haz_go_addr", mem_addr, 32'h106);
        idle(1'b0);

        // memory busy holds WAIT for three cycles
        step(1'b1, 1'b0, 32'h300, 32'h33333333, 4'b1111, 1'b0);
        idle(1'b0);
        chk("mb_drain", 32'(mem_memwrite), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 32'h400, 32'h0, 4'b0001, 1'b1);
            chk("mb_stall_busy", 32'(cpu_stall), 32'd1);
        end
        step(1'b0, 1'b1, 32'h400, 32'h0, 4'b0001, 1'b0);
        chk("mb_stall_wait", 32'(cpu_stall), 32'd1);
        step(1'b0, 1'b1, 32'h400, 32'h0, 4'b0001, 1'b0);
        chk("mb_go_stall", 32'(cpu_stall), 32'd0);
        chk("mb_go_rd", 32'(mem_memread), 32'd1);
        idle(1'b0);

        // fill to DEPTH, overflow stall and forced drain
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 32'h500 + 32'(4*k), 32'hA0 + 32'(k), 4'b1111, 1'b1);
            chk("fill_stall", 32'(cpu_stall), 32'd0);
        end
        step(1'b1, 1'b0, 32'h510, 32'hA4, 4'b1111, 1'b0);
        chk("full_count", 32'(sb_count), 32'd4);
        chk("full_stall", 32'(cpu_stall), 32'd1);
        chk("full_drain", 32'(mem_memwrite), 32'd1);
        chk("full_drain_addr", mem_addr, 32'h500);
        step(1'b1, 1'b0, 32'h510, 32'hA4, 4'b1111, 1'b0);
        chk("full_nopush_cnt", 32'(sb_count), 32'd3);
        chk("full_retry_stall", 32'(cpu_stall), 32'd0);
        idle(1'b0);
        chk("full_refill_cnt", 32'(sb_count), 32'd4);
        chk("full_drain2_addr", mem_addr, 32'h504);
        step(1'b1, 1'b0, 32'h514, 32'hA5, 4'b1111, 1'b0);
        step(1'b0, 1'b1, 32'h600, 32'h0, 4'b0001, 1'b0);
        chk("starve_stall", 32'(cpu_stall), 32'd1);
        chk("starve_drain", 32'(mem_memwrite), 32'd1);
        chk("starve_addr", mem_addr, 32'h508);
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            idle(1'b0);
            if (sb_empty) done = 1'b1;
        end
        chk("drain_done", 32'(done), 32'd1);
        idle(1'b0);

        // reset while a write is outstanding
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b0, 32'h700 + 32'(4*k), 32'hC0 + 32'(k), 4'b1111, 1'b1);
        idle(1'b0);
        chk("rw_drain", 32'(mem_memwrite), 32'd1);
        idle(1'b1);
        chk("rw_count", 32'(sb_count), 32'd2);
        reset = 1'b1;
        #1;
        chk("rw_rst_count", 32'(sb_count), 32'd0);
        chk("rw_rst_empty", 32'(sb_empty), 32'd1);
        chk("rw_rst_memwrite", 32'(mem_memwrite), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        mem_clk_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idle(1'b0);
            chk("rw_post_memwrite", 32'(mem_memwrite), 32'd0);
            chk("rw_post_count", 32'(sb_count), 32'd0);
        end

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
